// File: rtl/spi_mon_pkg.sv
// +------------------------------------------------------------------+
// | spi_mon_pkg: shared types and constants for the SPI slave monitor |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package spi_mon_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam int         REC_ADDR_W = 32;
  localparam int         REC_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    DATA   = 3'd4,
    IGNORE = 3'd5
  } state_e;

  typedef struct packed {
    logic [7:0]            cmd;
    logic [REC_ADDR_W-1:0] addr;
    logic [REC_DATA_W-1:0] data;
    logic                  is_read;
  } record_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mon_rsp_buf.sv
// +------------------------------------------------------------------+
// | spi_mon_rsp_buf: single-entry valid/ready record buffer with      |
// | sticky overflow and accepted-record counter. Rev 1.0              |
// +------------------------------------------------------------------+
`default_nettype none

module spi_mon_rsp_buf
  import spi_mon_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push,
  input  record_t     push_rec,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output record_t     rsp_rec,
  output logic        overflow,
  output logic [15:0] txn_count
);

  logic        r_valid;
  record_t     r_rec;
  logic        r_overflow;
  logic [15:0] r_txn_count;
  logic        w_pop;
  logic        w_load;

  // A pop frees the slot in the same cycle, so a simultaneous push is kept.
  assign w_pop  = r_valid & rsp_ready;
  assign w_load = push & (~r_valid | w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= 1'b0;
      r_rec       <= '0;
      r_overflow  <= 1'b0;
      r_txn_count <= 16'd0;
    end else begin
      if (w_load) begin
        r_valid     <= 1'b1;
        r_rec       <= push_rec;
        r_txn_count <= r_txn_count + 16'd1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      if (push && !w_load) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_rec   = r_rec;
  assign overflow  = r_overflow;
  assign txn_count = r_txn_count;

endmodule

`default_nettype wire

// File: rtl/spi_slave_monitor.sv
// +------------------------------------------------------------------+
// | spi_slave_monitor: passive SPI decoder turning write/read-memory  |
// | transactions into records on a valid/ready port. Rev 1.0          |
// +------------------------------------------------------------------+
`default_nettype none

module spi_slave_monitor #(
  parameter logic [7:0] CMD_WRITE    = spi_mon_pkg::CMD_WRITE,
  parameter logic [7:0] CMD_READ     = spi_mon_pkg::CMD_READ,
  parameter int         ADDR_W       = 32,
  parameter int         DATA_W       = 32,
  parameter int         DUMMY_CYCLES = 34
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              spi_sclk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  input  logic              spi_miso,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_cmd,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_is_read,
  output logic              err_cmd,
  output logic              err_abort,
  output logic              overflow,
  output logic [15:0]       txn_count
);

  import spi_mon_pkg::*;

  localparam int SHIFT_W = max3(ADDR_W, DATA_W, 8);
  localparam int CNT_W   = $clog2(max3(ADDR_W, DATA_W, DUMMY_CYCLES) + 1);

  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_CMD   = CNT_W'(8);
  localparam logic [CNT_W-1:0] C_CNT_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] C_CNT_DUMMY = CNT_W'(DUMMY_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_DATA  = CNT_W'(DATA_W);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SHIFT_W-2:0] r_shift;
  logic [SHIFT_W-1:0] w_shift_nxt;
  logic [7:0]         r_cmd;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_is_read;
  logic               r_sclk_q, r_cs_q;
  logic               r_err_cmd, r_err_abort;
  logic               w_sample, w_cs_fall, w_bit, w_last, w_opcode_ok;
  logic [7:0]         w_opcode;
  logic               w_err_cmd, w_err_abort, w_commit;
  record_t            w_rec, w_buf_rec;

  assign w_sample    = ~spi_cs & ~r_sclk_q & spi_sclk;
  assign w_cs_fall   = r_cs_q & ~spi_cs;
  assign w_bit       = (r_state == DATA && r_is_read) ? spi_miso : spi_mosi;
  assign w_shift_nxt = {r_shift, w_bit};
  assign w_opcode    = w_shift_nxt[7:0];
  assign w_opcode_ok = (w_opcode == CMD_WRITE) || (w_opcode == CMD_READ);
  assign w_last      = (r_cnt == C_CNT_ONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_cmd       <= 8'd0;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_sclk_q    <= 1'b0;
      r_cs_q      <= 1'b0;
      r_err_cmd   <= 1'b0;
      r_err_abort <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sclk_q    <= spi_sclk;
      r_cs_q      <= spi_cs;
      r_err_cmd   <= w_err_cmd;
      r_err_abort <= w_err_abort;
      if (w_state_nxt == IDLE) begin
        r_shift   <= '0;
        r_cmd     <= 8'd0;
        r_addr    <= '0;
        r_is_read <= 1'b0;
      end else if (w_sample) begin
        r_shift <= w_shift_nxt[SHIFT_W-2:0];
        if (w_last && r_state == CMD) begin
          r_cmd     <= w_opcode;
          r_is_read <= (w_opcode == CMD_READ);
        end
        if (w_last && r_state == ADDR) begin
          r_addr <= w_shift_nxt[ADDR_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = CMD;
          w_cnt_nxt   = C_CNT_CMD;
        end
      end
      IGNORE: begin
        if (spi_cs) w_state_nxt = IDLE;
      end
      default: begin
        if (spi_cs) begin
          w_state_nxt = IDLE;
        end else if (w_sample) begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
          if (w_last) begin
            case (r_state)
              CMD: begin
                w_state_nxt = w_opcode_ok ? ADDR : IGNORE;
                w_cnt_nxt   = w_opcode_ok ? C_CNT_ADDR : '0;
              end
              ADDR: begin
                w_state_nxt = r_is_read ? DUMMY : DATA;
                w_cnt_nxt   = r_is_read ? C_CNT_DUMMY : C_CNT_DATA;
              end
              DUMMY: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = C_CNT_DATA;
              end
              // CS stays low between back-to-back transactions.
              DATA: begin
                w_state_nxt = CMD;
                w_cnt_nxt   = C_CNT_CMD;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    w_err_cmd   = 1'b0;
    w_err_abort = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      CMD: begin
        if (spi_cs) w_err_abort = (r_cnt != C_CNT_CMD);
        else        w_err_cmd   = w_sample & w_last & ~w_opcode_ok;
      end
      ADDR, DUMMY: w_err_abort = spi_cs;
      DATA: begin
        w_err_abort = spi_cs;
        w_commit    = w_sample & w_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rec         = '0;
    w_rec.cmd     = r_cmd;
    w_rec.addr    = REC_ADDR_W'(r_addr);
    w_rec.data    = REC_DATA_W'(w_shift_nxt[DATA_W-1:0]);
    w_rec.is_read = r_is_read;
  end

  spi_mon_rsp_buf u_rsp_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (w_commit),
    .push_rec  (w_rec),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_rec   (w_buf_rec),
    .overflow  (overflow),
    .txn_count (txn_count)
  );

  assign rsp_cmd     = w_buf_rec.cmd;
  assign rsp_addr    = w_buf_rec.addr[ADDR_W-1:0];
  assign rsp_data    = w_buf_rec.data[DATA_W-1:0];
  assign rsp_is_read = w_buf_rec.is_read;
  assign err_cmd     = r_err_cmd;
  assign err_abort   = r_err_abort;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_monitor.sv
// +------------------------------------------------------------------+
// | tb_spi_slave_monitor: directed self-checking bench for            |
// | spi_slave_monitor. Rev 1.0                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_spi_slave_monitor;

  typedef logic [72:0] rec_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        spi_sclk, spi_cs, spi_mosi, spi_miso;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_cmd;
  logic [31:0] rsp_addr, rsp_data;
  logic        rsp_is_read, err_cmd, err_abort, overflow;
  logic [15:0] txn_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_err_cmd = 0;
  int   n_err_abort = 0;
  int   e_cmd, e_ab;
  rec_t rec_q[$];

  always #5 clk = ~clk;

  spi_slave_monitor dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .spi_sclk    (spi_sclk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_cmd     (rsp_cmd),
    .rsp_addr    (rsp_addr),
    .rsp_data    (rsp_data),
    .rsp_is_read (rsp_is_read),
    .err_cmd     (err_cmd),
    .err_abort   (err_abort),
    .overflow    (overflow),
    .txn_count   (txn_count)
  );

  // Logs handshakes and error pulses mid-cycle, after the bench has driven inputs.
  always begin
    @(negedge clk);
    #1;
    if (rsp_valid && rsp_ready) rec_q.push_back({rsp_cmd, rsp_addr, rsp_data, rsp_is_read});
    if (err_cmd) n_err_cmd++;
    if (err_abort) n_err_abort++;
  end

  task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic rec_t mk(input logic [7:0] c, input logic [31:0] a,
                              input logic [31:0] d, input logic r);
    return {c, a, d, r};
  endfunction

  function automatic rec_t cur_rec();
    return {rsp_cmd, rsp_addr, rsp_data, rsp_is_read};
  endfunction

  task automatic spi_bit(input logic m, input logic s);
    @(negedge clk);
    spi_sclk = 1'b0;
    spi_mosi = m;
    spi_miso = s;
    @(negedge clk);
    spi_sclk = 1'b1;
  endtask

  task automatic shift_out(input logic [63:0] v, input int n, input logic on_miso);
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(on_miso ? 1'b0 : v[i], on_miso ? v[i] : 1'b0);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    spi_sclk = 1'b0;
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    shift_out(64'h02, 8, 1'b0);
    shift_out({32'd0, a}, 32, 1'b0);
    shift_out({32'd0, d}, 32, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d);
    shift_out(64'h0B, 8, 1'b0);
    shift_out({32'd0, a}, 32, 1'b0);
    shift_out(64'd0, 34, 1'b0);
    shift_out({32'd0, d}, 32, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b0;
    spi_mosi = 1'b0; spi_miso = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_rec", cur_rec(), 0);
    check("rst_errs", {err_cmd, err_abort}, 0);
    check("rst_ovf", overflow, 0);
    check("rst_txn", txn_count, 0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);

    // Single write
    cs_low();
    do_write(32'h64, 32'h64);
    check("wr_pre_valid", rsp_valid, 0);
    @(negedge clk);
    check("wr_valid", rsp_valid, 1);
    check("wr_rec", cur_rec(), mk(8'h02, 32'h64, 32'h64, 1'b0));
    check("wr_txn", txn_count, 1);
    cs_high();

    // Single read, valid exactly one cycle after the last data sample
    cs_low();
    do_read(32'h64, 32'hDEADBEEF);
    check("rd_pre_valid", rsp_valid, 0);
    @(negedge clk);
    check("rd_valid", rsp_valid, 1);
    check("rd_rec", cur_rec(), mk(8'h0B, 32'h64, 32'hDEADBEEF, 1'b1));
    check("rd_txn", txn_count, 2);
    cs_high();
    check("rd_no_err", {n_err_cmd, n_err_abort}, 0);

    // Back-to-back write then read with CS held low
    rec_q.delete();
    cs_low();
    do_write(32'h100, 32'hA5A50001);
    do_read(32'h200, 32'h12345678);
    cs_high();
    check("b2b_count", rec_q.size(), 2);
    check("b2b_rec0", rec_q[0], mk(8'h02, 32'h100, 32'hA5A50001, 1'b0));
    check("b2b_rec1", rec_q[1], mk(8'h0B, 32'h200, 32'h12345678, 1'b1));
    check("b2b_txn", txn_count, 4);
    check("b2b_no_err", {n_err_cmd, n_err_abort}, 0);

    // Same sequence with consumer stalled: second record dropped
    rec_q.delete();
    rsp_ready = 1'b0;
    cs_low();
    do_write(32'h300, 32'hCAFE0003);
    @(negedge clk);
    check("ovf_first", cur_rec(), mk(8'h02, 32'h300, 32'hCAFE0003, 1'b0));
    check("ovf_pre_flag", overflow, 0);
    do_read(32'h400, 32'h0BADF00D);
    @(negedge clk);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", rsp_valid, 1);
    check("ovf_hold", cur_rec(), mk(8'h02, 32'h300, 32'hCAFE0003, 1'b0));
    check("ovf_txn", txn_count, 5);
    cs_high();
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovf_pop_count", rec_q.size(), 1);
    check("ovf_pop_rec", rec_q[0], mk(8'h02, 32'h300, 32'hCAFE0003, 1'b0));
    check("ovf_drained", rsp_valid, 0);
    check("ovf_sticky", overflow, 1);

    // CS rises after 20 address bits
    rec_q.delete();
    e_cmd = n_err_cmd; e_ab = n_err_abort;
    cs_low();
    shift_out(64'h02, 8, 1'b0);
    shift_out(64'h12345, 20, 1'b0);
    cs_high();
    check("abort_pulse", n_err_abort - e_ab, 1);
    check("abort_no_cmd_err", n_err_cmd - e_cmd, 0);
    check("abort_no_rec", rec_q.size(), 0);
    cs_low();
    do_write(32'h64, 32'h5555AAAA);
    cs_high();
    check("abort_recover_count", rec_q.size(), 1);
    check("abort_recover_rec", rec_q[0], mk(8'h02, 32'h64, 32'h5555AAAA, 1'b0));
    check("abort_recover_txn", txn_count, 6);

    // Unknown opcode 0x05; trailing bits must be ignored
    rec_q.delete();
    e_cmd = n_err_cmd; e_ab = n_err_abort;
    cs_low();
    shift_out(64'h05, 8, 1'b0);
    shift_out(64'h02000000_64FFFFFF, 64, 1'b0);
    cs_high();
    check("badop_pulse", n_err_cmd - e_cmd, 1);
    check("badop_no_abort", n_err_abort - e_ab, 0);
    check("badop_no_rec", rec_q.size(), 0);
    cs_low();
    do_write(32'h80, 32'h13579BDF);
    cs_high();
    check("badop_recover_rec", rec_q[0], mk(8'h02, 32'h80, 32'h13579BDF, 1'b0));
    check("badop_recover_txn", txn_count, 7);

    // Asynchronous reset in the middle of read data
    cs_low();
    shift_out(64'h0B, 8, 1'b0);
    shift_out(64'h64, 32, 1'b0);
    shift_out(64'd0, 34, 1'b0);
    shift_out(64'hDEAD, 16, 1'b1);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("mrst_valid", rsp_valid, 0);
    check("mrst_rec", cur_rec(), 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_txn", txn_count, 0);
    check("mrst_errs", {err_cmd, err_abort}, 0);
    check("mrst_state", dut.r_state, 0);
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    rec_q.delete();
    cs_low();
    do_write(32'h64, 32'h64);
    cs_high();
    check("post_rst_count", rec_q.size(), 1);
    check("post_rst_rec", rec_q[0], mk(8'h02, 32'h64, 32'h64, 1'b0));
    check("post_rst_txn", txn_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
